// File: rtl/sprite_blitter.sv
// CHIP-8 blit engine: framebuffer clear and XOR sprite draw with collision flag.
// Sprite bytes come from main RAM; the framebuffer is updated by read-modify-write.
module sprite_blitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        hires,
  input  logic [2:0]  blit_op,
  input  logic [11:0] blit_src,
  input  logic [3:0]  blit_srcHeight,
  input  logic [6:0]  blit_destX,
  input  logic [5:0]  blit_destY,
  input  logic        blit_enable,
  output logic        busy,
  output logic        collision,
  output logic        src_en,
  output logic [11:0] src_addr,
  input  logic [7:0]  src_data,
  output logic        fb_en,
  output logic        fb_wr,
  output logic [9:0]  fb_addr,
  output logic [7:0]  fb_in,
  input  logic [7:0]  fb_out
);

  localparam logic [2:0] BLIT_OP_CLEAR  = 3'd1;
  localparam logic [2:0] BLIT_OP_SPRITE = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SRC_ADDR, S_SRC_WAIT, S_SRC_LATCH,
    S_FB_ADDR, S_FB_WAIT, S_FB_WRITE
  } state_t;

  state_t      state_q;
  logic        busy_q, collision_q, src_en_q, fb_en_q, fb_wr_q;
  logic [11:0] src_addr_q;
  logic [9:0]  fb_addr_q;
  logic        hires_q, wide_q, byte_idx_q;
  logic [6:0]  x_q;
  logic [5:0]  row_q;
  logic [4:0]  rows_left_q;
  logic [1:0]  k_q;
  logic [7:0]  sprite_hi_q;
  logic [23:0] span_q;

  logic [15:0] spr_bits;
  logic [23:0] span_d;
  logic [7:0]  span_k;
  logic [1:0]  last_k;
  logic [5:0]  row_d;

  function automatic logic [3:0] col_of(input logic [3:0] base, input logic [1:0] k,
                                        input logic hi);
    logic [3:0] c;
    c = base + {2'b00, k};
    return hi ? c : {1'b0, c[2:0]};
  endfunction

  // Current source byte is used directly so the span is ready when leaving SRC_LATCH.
  assign spr_bits = wide_q ? {sprite_hi_q, src_data} : {src_data, 8'h00};
  assign span_d   = {spr_bits, 8'h00} >> x_q[2:0];
  assign last_k   = wide_q ? 2'd2 : 2'd1;
  assign row_d    = hires_q ? row_q + 6'd1 : {1'b0, row_q[4:0] + 5'd1};

  always_comb begin
    span_k = span_q[7:0];
    case (k_q)
      2'd0:    span_k = span_q[23:16];
      2'd1:    span_k = span_q[15:8];
      default: span_k = span_q[7:0];
    endcase
  end

  // Write data depends on the read returned this cycle, so it cannot be registered.
  assign fb_in     = (state_q == S_FB_WRITE) ? (fb_out ^ span_k) : '0;
  assign busy      = busy_q;
  assign collision = collision_q;
  assign src_en    = src_en_q;
  assign src_addr  = src_addr_q;
  assign fb_en     = fb_en_q;
  assign fb_wr     = fb_wr_q;
  assign fb_addr   = fb_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      collision_q <= 1'b0;
      src_en_q    <= 1'b0;
      fb_en_q     <= 1'b0;
      fb_wr_q     <= 1'b0;
      src_addr_q  <= '0;
      fb_addr_q   <= '0;
      hires_q     <= 1'b0;
      wide_q      <= 1'b0;
      byte_idx_q  <= 1'b0;
      x_q         <= '0;
      row_q       <= '0;
      rows_left_q <= '0;
      k_q         <= '0;
      sprite_hi_q <= '0;
      span_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (blit_enable) begin
            hires_q     <= hires;
            x_q         <= hires ? blit_destX : {1'b0, blit_destX[5:0]};
            row_q       <= hires ? blit_destY : {1'b0, blit_destY[4:0]};
            src_addr_q  <= blit_src;
            wide_q      <= (blit_srcHeight == 4'd0);
            rows_left_q <= (blit_srcHeight == 4'd0) ? 5'd16 : {1'b0, blit_srcHeight};
            byte_idx_q  <= 1'b0;
            collision_q <= 1'b0;
            if (blit_op == BLIT_OP_CLEAR) begin
              state_q   <= S_CLEAR;
              busy_q    <= 1'b1;
              fb_en_q   <= 1'b1;
              fb_wr_q   <= 1'b1;
              fb_addr_q <= '0;
            end else if (blit_op == BLIT_OP_SPRITE && (blit_srcHeight != 4'd0 || hires)) begin
              state_q  <= S_SRC_ADDR;
              busy_q   <= 1'b1;
              src_en_q <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (fb_addr_q == 10'd1023) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            fb_en_q <= 1'b0;
            fb_wr_q <= 1'b0;
          end else begin
            fb_addr_q <= fb_addr_q + 10'd1;
          end
        end
        S_SRC_ADDR: begin
          src_en_q <= 1'b0;
          state_q  <= S_SRC_WAIT;
        end
        S_SRC_WAIT: state_q <= S_SRC_LATCH;
        S_SRC_LATCH: begin
          src_addr_q <= src_addr_q + 12'd1;
          if (wide_q && !byte_idx_q) begin
            sprite_hi_q <= src_data;
            byte_idx_q  <= 1'b1;
            src_en_q    <= 1'b1;
            state_q     <= S_SRC_ADDR;
          end else begin
            span_q    <= span_d;
            k_q       <= 2'd0;
            fb_en_q   <= 1'b1;
            fb_addr_q <= {row_q, col_of(x_q[6:3], 2'd0, hires_q)};
            state_q   <= S_FB_ADDR;
          end
        end
        S_FB_ADDR: begin
          fb_en_q <= 1'b0;
          state_q <= S_FB_WAIT;
        end
        S_FB_WAIT: begin
          fb_en_q <= 1'b1;
          fb_wr_q <= 1'b1;
          state_q <= S_FB_WRITE;
        end
        S_FB_WRITE: begin
          collision_q <= collision_q | (|(fb_out & span_k));
          fb_wr_q     <= 1'b0;
          if (k_q == last_k) begin
            fb_en_q <= 1'b0;
            if (rows_left_q == 5'd1) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              rows_left_q <= rows_left_q - 5'd1;
              row_q       <= row_d;
              byte_idx_q  <= 1'b0;
              src_en_q    <= 1'b1;
              state_q     <= S_SRC_ADDR;
            end
          end else begin
            k_q       <= k_q + 2'd1;
            fb_addr_q <= {row_q, col_of(x_q[6:3], k_q + 2'd1, hires_q)};
            state_q   <= S_FB_ADDR;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected framebuffer writes and command
// completions are queued by the stimulus and consumed by a negedge monitor.
module tb_sprite_blitter;

  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SPRITE = 3'd2;

  logic        clk, rst, hires, blit_enable;
  logic [2:0]  blit_op;
  logic [11:0] blit_src;
  logic [3:0]  blit_srcHeight;
  logic [6:0]  blit_destX;
  logic [5:0]  blit_destY;
  logic        busy, collision, src_en, fb_en, fb_wr;
  logic [11:0] src_addr;
  logic [7:0]  src_data, fb_in, fb_out;
  logic [9:0]  fb_addr;

  sprite_blitter dut (
    .clk(clk), .rst(rst), .hires(hires), .blit_op(blit_op), .blit_src(blit_src),
    .blit_srcHeight(blit_srcHeight), .blit_destX(blit_destX), .blit_destY(blit_destY),
    .blit_enable(blit_enable), .busy(busy), .collision(collision),
    .src_en(src_en), .src_addr(src_addr), .src_data(src_data),
    .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_in(fb_in), .fb_out(fb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle read latency RAM models
  logic [7:0] mem [4096];
  logic [7:0] fbm [1024];
  logic [7:0] sp, fp;
  logic       bd_we;
  logic [9:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (src_en) sp <= mem[src_addr];
    src_data <= sp;
  end

  always @(posedge clk) begin
    if (bd_we) fbm[bd_addr] <= bd_data;
    else if (fb_en) begin
      if (fb_wr) fbm[fb_addr] <= fb_in;
      else fp <= fbm[fb_addr];
    end
    fb_out <= fp;
  end

  typedef struct packed { logic [9:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [31:0] cyc; logic col; } done_t;
  wr_t   exp_wr[$];
  done_t exp_done[$];
  wr_t   mw;
  done_t md;

  int unsigned checks = 0, errors = 0, run = 0;
  logic aborting = 1'b0;

  always @(negedge clk) begin
    if (fb_en && fb_wr && !rst) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%h data=%h, none required", fb_addr, fb_in);
      end else begin
        mw = exp_wr.pop_front();
        if (fb_addr !== mw.a || fb_in !== mw.d) begin
          errors++;
          $display("FAIL fb_write: got addr=%h data=%h, required addr=%h data=%h",
                   fb_addr, fb_in, mw.a, mw.d);
        end
      end
    end
    if (busy) run++;
    else if (run != 0) begin
      if (!aborting) begin
        checks++;
        if (exp_done.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: busy ran %0d cycles", run);
        end else begin
          md = exp_done.pop_front();
          if (run !== md.cyc || collision !== md.col) begin
            errors++;
            $display("FAIL cmd_done: got busy=%0d collision=%b, required busy=%0d collision=%b",
                     run, collision, md.cyc, md.col);
          end
        end
      end
      run = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic cmd(input logic [2:0] op, input logic [11:0] src, input logic [3:0] h,
                     input logic [6:0] x, input logic [5:0] y, input logic hi);
    @(negedge clk);
    blit_op = op; blit_src = src; blit_srcHeight = h;
    blit_destX = x; blit_destY = y; hires = hi; blit_enable = 1'b1;
    @(negedge clk);
    blit_enable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic bd_fill(input logic rnd);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bd_we = 1'b1;
      bd_addr = i[9:0];
      bd_data = rnd ? (8'($urandom) | 8'h01) : 8'h00;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not end, required completion");
    $fatal(1);
  end

  initial begin
    int nz;
    int r;
    rst = 1'b1; hires = 1'b0; blit_enable = 1'b0; blit_op = '0; blit_src = '0;
    blit_srcHeight = '0; blit_destX = '0; blit_destY = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_collision", collision, 0);
    check("rst_src_en", src_en, 0);
    check("rst_src_addr", src_addr, 0);
    check("rst_fb_en", fb_en, 0);
    check("rst_fb_wr", fb_wr, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_in", fb_in, 0);
    rst = 1'b0;

    // CLEAR over random contents, with an ignored strobe mid-command
    bd_fill(1'b1);
    for (int i = 0; i < 1024; i++) exp_wr.push_back({10'(i), 8'h00});
    exp_done.push_back({32'd1024, 1'b0});
    cmd(OP_CLEAR, 12'h000, 4'd0, 7'd0, 6'd0, 1'b0);
    repeat (100) @(negedge clk);
    blit_op = OP_SPRITE; blit_srcHeight = 4'd1; blit_enable = 1'b1;
    @(negedge clk);
    blit_enable = 1'b0;
    wait_idle("clear");
    nz = 0;
    for (int i = 0; i < 1024; i++) if (fbm[i] != 8'h00) nz++;
    check("clear_all_zero", nz, 0);

    // Lores 8x1 sprite at origin, then again to collide
    mem[12'h300] = 8'hF0;
    exp_wr.push_back({10'h000, 8'hF0});
    exp_wr.push_back({10'h001, 8'h00});
    exp_done.push_back({32'd9, 1'b0});
    cmd(OP_SPRITE, 12'h300, 4'd1, 7'd0, 6'd0, 1'b0);
    wait_idle("sprite1");
    check("sprite1_fb0", fbm[0], 8'hF0);
    exp_wr.push_back({10'h000, 8'h00});
    exp_wr.push_back({10'h001, 8'h00});
    exp_done.push_back({32'd9, 1'b1});
    cmd(OP_SPRITE, 12'h300, 4'd1, 7'd0, 6'd0, 1'b0);
    wait_idle("sprite2");
    check("sprite2_collision", collision, 1);

    // Unknown op completes at once and clears collision; lores h=0 likewise
    cmd(3'd7, 12'h300, 4'd1, 7'd0, 6'd0, 1'b0);
    check("unk_busy", busy, 0);
    check("unk_collision", collision, 0);
    cmd(OP_SPRITE, 12'h300, 4'd0, 7'd0, 6'd0, 1'b0);
    check("lores_h0_busy", busy, 0);
    check("lores_h0_src_en", src_en, 0);

    // Lores wrap: X=124 -> 60, Y=63 -> 31
    for (int i = 0; i < 3; i++) mem[12'h310 + i] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      r = (31 + i) % 32;
      exp_wr.push_back({6'(r), 4'd7, 8'h08});
      exp_wr.push_back({6'(r), 4'd0, 8'h10});
    end
    exp_done.push_back({32'd27, 1'b0});
    cmd(OP_SPRITE, 12'h310, 4'd3, 7'd124, 6'd63, 1'b0);
    wait_idle("lores_wrap");

    // Hires 16x16 at X=4, Y=62 on a blank framebuffer
    bd_fill(1'b0);
    for (int i = 0; i < 32; i++) mem[12'h400 + i] = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      r = (62 + i) % 64;
      exp_wr.push_back({6'(r), 4'd0, 8'h0F});
      exp_wr.push_back({6'(r), 4'd1, 8'hFF});
      exp_wr.push_back({6'(r), 4'd2, 8'hF0});
    end
    exp_done.push_back({32'd240, 1'b0});
    cmd(OP_SPRITE, 12'h400, 4'd0, 7'd4, 6'd62, 1'b1);
    wait_idle("hires16");
    check("hires_row13_col1", fbm[{6'd13, 4'd1}], 8'hFF);

    // Reset during source fetch, then a fresh sprite
    mem[12'h320] = 8'h18;
    cmd(OP_SPRITE, 12'h320, 4'd1, 7'd0, 6'd0, 1'b0);
    repeat (2) @(negedge clk);
    aborting = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_collision", collision, 0);
    check("abort_src_en", src_en, 0);
    check("abort_fb_en", fb_en, 0);
    check("abort_fb_wr", fb_wr, 0);
    rst = 1'b0;
    @(negedge clk);
    aborting = 1'b0;
    exp_wr.push_back({10'h000, 8'h17});
    exp_wr.push_back({10'h001, 8'hFF});
    exp_done.push_back({32'd9, 1'b1});
    cmd(OP_SPRITE, 12'h320, 4'd1, 7'd0, 6'd0, 1'b0);
    wait_idle("after_abort");

    repeat (3) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("done_queue_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Executes the blit commands issued by the CHIP-8 CPU's `blit_*` outputs: framebuffer clear and XOR sprite draw with collision detection. The block fetches sprite bytes from main RAM through its own read port and performs read-modify-write on a byte-wide 128x64 monochrome framebuffer RAM. Display scan-out reads the same framebuffer through a separate port.

## Interface
Parameters: none.
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `hires` in 1: 1 = 128x64 mode, 0 = 64x32 mode, using the top-left 64x32 region of the framebuffer.
- `blit_op` in 3: command; encodings `BLIT_OP_*` from blitter.vh.
- `blit_src` in 12: sprite address in main RAM.
- `blit_srcHeight` in 4: sprite rows; 0 has special meaning, see Operation.
- `blit_destX` in 7 / `blit_destY` in 6: sprite origin in pixels.
- `blit_enable` in 1: command strobe, sampled every cycle.
- `busy` out 1: command in progress.
- `collision` out 1: result for VF from the last completed sprite.
- `src_en` out 1, `src_addr` out 12, `src_data` in 8: main RAM read port.
- `fb_en` out 1, `fb_wr` out 1, `fb_addr` out 10, `fb_in` out 8, `fb_out` in 8: framebuffer port.
  - `fb_addr` = {row[5:0], col[3:0]}.
  - Bit 7 of each byte is the leftmost pixel.

## Operation
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset mid-command abandons the command; bytes already written stay written.
- Command acceptance: `blit_enable`=1 is accepted only in IDLE. A strobe while `busy`=1 is ignored.
- On acceptance:
  - latch op, src, height, and `hires`;
  - latch X and Y, wrapped to the mode: lores X mod 64, Y mod 32; hires X mod 128, Y mod 64;
  - clear `collision`.
- Any op other than `BLIT_OP_SPRITE` or `BLIT_OP_CLEAR` completes in the acceptance cycle (`busy` never rises).
- `BLIT_OP_CLEAR`: state CLEAR writes 0x00 to fb_addr 0..1023, one byte per cycle. `collision` stays 0.
- `BLIT_OP_SPRITE` sprite geometry:
  - Width W = 16 pixels and 16 rows when height=0 and hires=1. Otherwise W = 8 and rows = height.
  - height=0 in lores completes immediately, as for an unknown op.
- Per sprite row r (row address = (Y+r) mod rows-in-mode):
  - SRC_ADDR → SRC_WAIT → SRC_LATCH, once per sprite byte (1 or 2 bytes).
  - Source address = src + byte index; it increments across rows and wraps at 12 bits.
  - Form the shifted row: {sprite bits, 8'h00} >> X[2:0]. This gives 16 bits (W=8) or 24 bits (W=16), spanning N = 2 or 3 framebuffer bytes.
  - For each span byte k = 0..N-1:
    - FB_ADDR issues a read at col = (X[6:3]+k) mod cols-in-mode (8 lores, 16 hires);
    - FB_WAIT;
    - FB_WRITE writes `fb_out ^ span_k` and ORs `|(fb_out & span_k)` into `collision`.
  - All span bytes are written even when span_k = 0.
- After the last row, return to IDLE.

## Timing
- RAM read latency: data is valid on the second rising edge after the edge that registers the address. The WAIT state covers this.
- Framebuffer writes take effect on the edge at which `fb_wr`=1.
- `busy` rises on the edge that accepts the command and falls on the edge of the last framebuffer write.
- `busy` duration:
  - CLEAR: exactly 1024 cycles.
  - 8-wide sprite: 9 cycles per row (3 source + 2x3 framebuffer).
  - 16x16 sprite: 15 cycles per row, 240 total.
- `collision` is valid when `busy` falls. It holds until the next accepted command.
- `src_en` and `fb_en` are 1 only in the states that use their port. `fb_wr` is 1 only in FB_WRITE and CLEAR.

## Test plan
- Lores, framebuffer cleared, RAM[0x300]=0xF0, sprite src=0x300, h=1, X=0, Y=0:
  - fb[0x000]=0xF0, fb[0x001]=0x00, collision=0;
  - busy high exactly 9 cycles.
- Repeat the same sprite: fb[0x000]=0x00, collision=1.
- Lores, byte 0x81 at X=60, Y=31, h=3:
  - in each of rows 31, 0, 1: col7 = 0x08 and col0 = 0x10 (X and Y wrap);
  - busy = 27 cycles.
- Hires, h=0, RAM 32 bytes of 0xFF, X=4, Y=62:
  - rows 62, 63, 0..13 each get cols 0=0x0F, 1=0xFF, 2=0xF0;
  - busy = 240 cycles.
- CLEAR after random fill:
  - all 1024 bytes read 0x00, busy = 1024 cycles, collision=0;
  - a second `blit_enable` pulse mid-clear is ignored.
- Assert `rst` for 1 cycle mid-sprite:
  - next cycle busy=0, collision=0, all enables 0;
  - a new sprite command is then accepted normally.
